link_arbiter: RTL and testbench
===============================

Name: link_arbiter

Overview:
- Round-robin arbiter that shares one downstream 4-phase req/ack byte link (the slave side of link_top) between NREQ upstream masters.
- Each upstream master sees a normal 4-phase slave. The arbiter forwards the granted master's data and handshake downstream.
- The arbiter holds the grant for one complete 4-phase transaction, then rotates priority.
- It also counts completed transfers for status and debug.

Parameters:
NREQ, 2, number of upstream requesters (2..8)
DW, 8, data width per requester
CW, 16, transfer counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_in  in  NREQ  upstream request, bit i from master i
data_in  in  NREQ*DW  upstream data, master i on bits [i*DW +: DW]
ack_out  out  NREQ  upstream acknowledge, one-hot or zero
req_o  out  1  downstream request
data_o  out  DW  downstream data, registered
ack_i  in  1  downstream acknowledge
grant  out  NREQ  one-hot current owner, zero when idle
busy  out  1  high whenever state != IDLE
xfer_count  out  CW  number of completed transactions

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; req_o=0, data_o=0, ack_out=0, grant=0, busy=0, xfer_count=0.
  - RR pointer=0, so requester 0 has highest priority first.
  - Reset mid-transaction aborts it immediately; no completion is counted.
- Arbitration happens only in IDLE:
  - Search req_in starting at pointer p, upward modulo NREQ; first set bit g wins.
  - Same edge: grant=onehot(g), data_o=data_in[g], req_o=1, state->WAIT_ACK.
  - Latency: req_in[g] rising to req_o high is 1 cycle.
- Fixed state sequence and outputs (required to match exactly):
  - IDLE: req_o=0, ack_out=0, grant=0. Waits for any req_in bit.
  - WAIT_ACK: req_o=1. On ack_i=1: ack_out[g]=1, state->WAIT_REQ_LOW.
  - WAIT_REQ_LOW: req_o=1, ack_out[g]=1. On req_in[g]=0: req_o=0, state->WAIT_ACK_LOW.
  - WAIT_ACK_LOW: req_o=0, ack_out[g]=1. On ack_i=0: ack_out=0, grant=0, xfer_count+=1, p=(g+1) mod NREQ, state->IDLE.
- Minimum transaction is 4 cycles when both ends respond immediately. Minimum turnaround is 1 IDLE cycle between transactions.
- data_o is latched once per grant and held stable until the next grant; later changes on data_in are ignored.
- Non-granted req_in bits are ignored outside IDLE; their ack_out bits stay 0.
- The transaction is committed once granted:
  - If req_in[g] drops during WAIT_ACK, req_o stays high until ack_i arrives.
  - The FSM then proceeds normally; WAIT_REQ_LOW exits the next cycle.
- If ack_i is already high on entering WAIT_ACK (protocol violation), it is taken as the acknowledge; no special handling.
- xfer_count wraps from 2^CW-1 to 0 silently.
- Fairness: with all requesters continuously active, grants cycle 0,1,..,NREQ-1,0.

Decomposition:
- Package link_pkg holds:
  - state enum: IDLE, WAIT_ACK, WAIT_REQ_LOW, WAIT_ACK_LOW (2-bit encoding);
  - DW default constant, shared with link master/slave.
- One sub-module, rr_pick: combinational round-robin priority encoder.
  - Inputs req vector and pointer; outputs one-hot grant and valid.
  - Reusable by other arbiters.
- FSM, data register and counter stay in link_arbiter.

Test Plan:
- Single requester (NREQ=2): master0 raises req with data 0xA5; slave acks 1 cycle after req_o.
  - Expect req_o high 1 cycle after req_in[0], data_o=A5, grant=01.
  - Expect ack_out[0] to follow ack_i; xfer_count=1.
  - Expect grant=00 and busy=0 after ack_i falls.
- Simultaneous requests: req_in=11 out of reset with data 0x11 and 0x22, each master re-requesting after completion.
  - Expect grant order 01,10,01,10 and data_o 11,22,11,22.
  - Expect ack_out[1] never high while grant=01; xfer_count=4.
- Data stability: change data_in[0] from 0x3C to 0xFF while in WAIT_ACK.
  - Expect data_o to remain 0x3C until the next grant.
- Early req drop: master0 deasserts req one cycle after grant, before ack.
  - Expect req_o to stay 1 until ack_i, then fall the next cycle; transaction completes and xfer_count increments.
- Reset mid-transfer: assert rst in WAIT_REQ_LOW.
  - Next edge: all outputs 0, xfer_count=0, grant=00.
  - Expect master0 to win first after release even if master1 was pending.
- Counter wrap (CW=4): run 17 transactions.
  - Expect xfer_count to read 15 after 15 transactions, 0 after 16, 1 after 17.

Source files
------------

// File: rtl/link_pkg.sv
// link_pkg: shared types and constants for the req/ack byte link family.
//   link_state_e : 4-phase handshake sequencer states (2-bit encoding)
//   LINK_DW      : default link data width, shared with link master/slave
package link_pkg;

  localparam int LINK_DW = 8;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_ACK     = 2'd1,
    WAIT_REQ_LOW = 2'd2,
    WAIT_ACK_LOW = 2'd3
  } link_state_e;

endpackage

// File: rtl/link_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req : request vector
//   ptr : index of the highest-priority requester this round
//   gnt : one-hot winner (first set bit at or above ptr, modulo N)
//   vld : at least one request is present
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  int   idx;
  logic found;

  // Walk the ring starting at ptr; the first asserted request wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign vld = |req;

endmodule

// File: rtl/link_arbiter.sv
// link_arbiter: shares one downstream 4-phase req/ack link between NREQ
// upstream masters, holding the grant for one full handshake and then
// rotating priority past the last owner.
//   clk, rst    : clock, synchronous active-high reset
//   req_in      : upstream requests, bit i from master i
//   data_in     : upstream data, master i on [i*DW +: DW]
//   ack_out     : upstream acknowledge (only the owner's bit can be set)
//   req_o       : downstream request
//   data_o      : downstream data, latched at grant
//   ack_i       : downstream acknowledge
//   grant       : one-hot current owner, zero when idle
//   busy        : a transaction is in flight
//   xfer_count  : completed transactions (wraps)
module link_arbiter
  import link_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = LINK_DW,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_in,
  input  logic [NREQ*DW-1:0] data_in,
  output logic [NREQ-1:0]    ack_out,
  output logic               req_o,
  output logic [DW-1:0]      data_o,
  input  logic               ack_i,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [CW-1:0]      xfer_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  link_state_e     state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   nxt_ptr;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [DW-1:0]   pick_data;
  logic            greq;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req (req_in),
    .ptr (ptr),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  // One-hot winner to index and data mux.
  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx  = PW'(i);
        pick_data = data_in[i*DW +: DW];
      end
    end
  end

  // Only the owner's request matters once granted.
  assign greq    = |(req_in & grant);
  assign nxt_ptr = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gidx       <= '0;
      grant      <= '0;
      ack_out    <= '0;
      req_o      <= 1'b0;
      data_o     <= '0;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant  <= pick_gnt;
            gidx   <= pick_idx;
            data_o <= pick_data;
            req_o  <= 1'b1;
            state  <= WAIT_ACK;
          end
        end
        // Committed: req_o stays up until ack even if the owner drops req.
        WAIT_ACK: begin
          if (ack_i) begin
            ack_out <= grant;
            state   <= WAIT_REQ_LOW;
          end
        end
        WAIT_REQ_LOW: begin
          if (!greq) begin
            req_o <= 1'b0;
            state <= WAIT_ACK_LOW;
          end
        end
        WAIT_ACK_LOW: begin
          if (!ack_i) begin
            ack_out    <= '0;
            grant      <= '0;
            xfer_count <= xfer_count + 1'b1;
            ptr        <= nxt_ptr;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_arbiter.sv
module tb_link_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 8;
  localparam int CW   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req_in;
  logic [NREQ*DW-1:0] data_in;
  logic [NREQ-1:0]  ack_out;
  logic             req_o;
  logic [DW-1:0]    data_o;
  logic             ack_i;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic [CW-1:0]    xfer_count;

  int errors = 0;
  int checks = 0;

  // Stimulus sources: manual (tasks) or automatic master/slave models.
  bit               auto_m    = 1'b0;
  bit               slave_en  = 1'b1;
  logic [1:0]       man_req   = '0;
  logic [15:0]      man_data  = '0;
  logic             man_ack   = 1'b0;
  logic [1:0]       auto_req  = '0;
  logic [15:0]      auto_data = '0;
  logic             slave_ack = 1'b0;
  logic [7:0]       mq0[$];
  logic [7:0]       mq1[$];

  typedef struct packed {logic [1:0] g; logic [7:0] d;} exp_t;
  exp_t             sb[$];
  logic [1:0]       prev_grant = '0;

  assign req_in  = auto_m ? auto_req : man_req;
  assign data_in = auto_m ? auto_data : man_data;
  assign ack_i   = slave_en ? slave_ack : man_ack;

  link_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .data_in    (data_in),
    .ack_out    (ack_out),
    .req_o      (req_o),
    .data_o     (data_o),
    .ack_i      (ack_i),
    .grant      (grant),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  // Downstream slave: acknowledges one cycle after req_o changes.
  always @(negedge clk) slave_ack = req_o;

  // Upstream masters: drop req on ack, re-request once ack is gone.
  always @(negedge clk) begin
    if (auto_m) begin
      if (auto_req[0] && ack_out[0]) auto_req[0] = 1'b0;
      else if (!auto_req[0] && !ack_out[0] && mq0.size() > 0) begin
        auto_data[7:0] = mq0.pop_front();
        auto_req[0]    = 1'b1;
      end
      if (auto_req[1] && ack_out[1]) auto_req[1] = 1'b0;
      else if (!auto_req[1] && !ack_out[1] && mq1.size() > 0) begin
        auto_data[15:8] = mq1.pop_front();
        auto_req[1]     = 1'b1;
      end
    end
  end

  // Scoreboard: every new grant must match the next expected owner/data.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_grant unexpected grant=%b data_o=%h", grant, data_o);
        end else begin
          e = sb.pop_front();
          if (grant !== e.g || data_o !== e.d) begin
            errors++;
            $display("FAIL sb_grant got grant=%b data_o=%h want grant=%b data_o=%h",
                     grant, data_o, e.g, e.d);
          end
        end
      end
      checks++;
      if ((ack_out & ~grant) !== 2'b00) begin
        errors++;
        $display("FAIL ack_excl ack_out=%b grant=%b", ack_out, grant);
      end
    end
    prev_grant = grant;
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack0(input bit v, input int budget, input string tag);
    int n = 0;
    while (ack_out[0] !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ack_out[0] !== v) begin
      errors++;
      $display("FAIL %s timeout ack_out[0]=%b want %b", tag, ack_out[0], v);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(busy === 1'b0 && req_in === 2'b00 && mq0.size() == 0 && mq1.size() == 0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(busy === 1'b0 && req_in === 2'b00)) begin
      errors++;
      $display("FAIL %s timeout busy=%b req_in=%b", tag, busy, req_in);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (req_o !== 1'b0)      begin errors++; $display("FAIL rst_req_o got %b want 0", req_o); end
    if (data_o !== 8'h00)    begin errors++; $display("FAIL rst_data_o got %h want 00", data_o); end
    if (ack_out !== 2'b00)   begin errors++; $display("FAIL rst_ack_out got %b want 00", ack_out); end
    if (grant !== 2'b00)     begin errors++; $display("FAIL rst_grant got %b want 00", grant); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (xfer_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", xfer_count); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    man_data[7:0] = 8'hA5;
    man_req       = 2'b01;
    sb.push_back(exp_t'{g: 2'b01, d: 8'hA5});
    @(negedge clk);
    checks += 3;
    if (req_o !== 1'b1)    begin errors++; $display("FAIL single_req_lat got %b want 1", req_o); end
    if (grant !== 2'b01)   begin errors++; $display("FAIL single_grant got %b want 01", grant); end
    if (ack_out !== 2'b00) begin errors++; $display("FAIL single_ack_early got %b want 00", ack_out); end
    @(negedge clk);
    checks++;
    if (ack_out !== 2'b01) begin errors++; $display("FAIL single_ack got %b want 01", ack_out); end
    man_req = 2'b00;
    @(negedge clk);
    checks += 2;
    if (req_o !== 1'b0)    begin errors++; $display("FAIL single_req_fall got %b want 0", req_o); end
    if (ack_out !== 2'b01) begin errors++; $display("FAIL single_ack_hold got %b want 01", ack_out); end
    @(negedge clk);
    checks += 4;
    if (grant !== 2'b00)     begin errors++; $display("FAIL single_grant_end got %b want 00", grant); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    if (ack_out !== 2'b00)   begin errors++; $display("FAIL single_ack_end got %b want 00", ack_out); end
    if (xfer_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", xfer_count); end
  endtask

  task automatic test_simul();
    do_reset();
    mq0 = '{8'h11, 8'h11};
    mq1 = '{8'h22, 8'h22};
    sb.push_back(exp_t'{g: 2'b01, d: 8'h11});
    sb.push_back(exp_t'{g: 2'b10, d: 8'h22});
    sb.push_back(exp_t'{g: 2'b01, d: 8'h11});
    sb.push_back(exp_t'{g: 2'b10, d: 8'h22});
    auto_m = 1'b1;
    wait_idle(200, "simul_done");
    auto_m = 1'b0;
    checks++;
    if (xfer_count !== 4'd4) begin errors++; $display("FAIL simul_count got %0d want 4", xfer_count); end
  endtask

  task automatic test_data_stable();
    do_reset();
    man_data[7:0] = 8'h3C;
    man_req       = 2'b01;
    sb.push_back(exp_t'{g: 2'b01, d: 8'h3C});
    @(negedge clk);
    man_data[7:0] = 8'hFF;
    checks++;
    if (data_o !== 8'h3C) begin errors++; $display("FAIL stable_wait_ack got %h want 3c", data_o); end
    @(negedge clk);
    checks++;
    if (data_o !== 8'h3C) begin errors++; $display("FAIL stable_req_low got %h want 3c", data_o); end
    man_req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0)    begin errors++; $display("FAIL stable_idle busy got %b want 0", busy); end
    if (data_o !== 8'h3C) begin errors++; $display("FAIL stable_held got %h want 3c", data_o); end
    man_req = 2'b01;
    sb.push_back(exp_t'{g: 2'b01, d: 8'hFF});
    @(negedge clk);
    checks++;
    if (data_o !== 8'hFF) begin errors++; $display("FAIL stable_regrant got %h want ff", data_o); end
    wait_ack0(1'b1, 20, "stable_ack");
    man_req = 2'b00;
    wait_idle(20, "stable_done");
  endtask

  task automatic test_early_drop();
    do_reset();
    slave_en      = 1'b0;
    man_ack       = 1'b0;
    man_data[7:0] = 8'h5A;
    man_req       = 2'b01;
    sb.push_back(exp_t'{g: 2'b01, d: 8'h5A});
    @(negedge clk);
    checks++;
    if (req_o !== 1'b1) begin errors++; $display("FAIL drop_req_up got %b want 1", req_o); end
    man_req = 2'b00;
    @(negedge clk);
    checks += 2;
    if (req_o !== 1'b1)    begin errors++; $display("FAIL drop_req_held got %b want 1", req_o); end
    if (ack_out !== 2'b00) begin errors++; $display("FAIL drop_ack_none got %b want 00", ack_out); end
    @(negedge clk);
    checks++;
    if (req_o !== 1'b1) begin errors++; $display("FAIL drop_req_held2 got %b want 1", req_o); end
    man_ack = 1'b1;
    @(negedge clk);
    checks += 2;
    if (ack_out !== 2'b01) begin errors++; $display("FAIL drop_ack got %b want 01", ack_out); end
    if (req_o !== 1'b1)    begin errors++; $display("FAIL drop_req_at_ack got %b want 1", req_o); end
    @(negedge clk);
    checks++;
    if (req_o !== 1'b0) begin errors++; $display("FAIL drop_req_fall got %b want 0", req_o); end
    man_ack = 1'b0;
    @(negedge clk);
    checks += 2;
    if (xfer_count !== 4'd1) begin errors++; $display("FAIL drop_count got %0d want 1", xfer_count); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL drop_busy got %b want 0", busy); end
    slave_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    man_data = {8'h99, 8'h77};
    man_req  = 2'b01;
    sb.push_back(exp_t'{g: 2'b01, d: 8'h77});
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ack_out !== 2'b01 || req_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_req_low got ack_out=%b req_o=%b want 01/1", ack_out, req_o);
    end
    rst     = 1'b1;
    man_req = 2'b11;
    @(negedge clk);
    checks += 6;
    if (req_o !== 1'b0)      begin errors++; $display("FAIL mid_req_o got %b want 0", req_o); end
    if (data_o !== 8'h00)    begin errors++; $display("FAIL mid_data_o got %h want 00", data_o); end
    if (ack_out !== 2'b00)   begin errors++; $display("FAIL mid_ack_out got %b want 00", ack_out); end
    if (grant !== 2'b00)     begin errors++; $display("FAIL mid_grant got %b want 00", grant); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    if (xfer_count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d want 0", xfer_count); end
    sb.push_back(exp_t'{g: 2'b01, d: 8'h77});
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL mid_first_owner got %b want 01", grant); end
    man_req = 2'b01;
    wait_ack0(1'b1, 20, "mid_ack");
    man_req = 2'b00;
    wait_idle(20, "mid_done");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      mq0.push_back(8'(i));
      sb.push_back(exp_t'{g: 2'b01, d: 8'(i)});
    end
    auto_m = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      wait_ack0(1'b1, 20, "wrap_ack_hi");
      wait_ack0(1'b0, 20, "wrap_ack_lo");
      if (t >= 15) begin
        checks++;
        if (xfer_count !== 4'(t % 16)) begin
          errors++;
          $display("FAIL wrap_count after %0d got %0d want %0d", t, xfer_count, t % 16);
        end
      end
    end
    wait_idle(20, "wrap_done");
    auto_m = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_simul();
    test_data_stable();
    test_early_drop();
    test_reset_mid();
    test_wrap();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
